// File: rtl/vx_issue_scoreboard.sv
// Issue-stage register scoreboard: per-warp busy bits gate decoded instructions
// into a one-entry issue slot; writeback EOP packets release reservations.
module vx_issue_scoreboard #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_REGS    = 64,
  parameter int STALL_LIMIT = 1023,
  parameter int PAYLOAD_W   = 16,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NR_BITS     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NW_BITS-1:0]   in_wid_i,
  input  logic [NR_BITS-1:0]   in_rd_i,
  input  logic [NR_BITS-1:0]   in_rs1_i,
  input  logic [NR_BITS-1:0]   in_rs2_i,
  input  logic [NR_BITS-1:0]   in_rs3_i,
  input  logic                 in_wb_i,
  input  logic                 in_use_rs3_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NW_BITS-1:0]   out_wid_o,
  output logic [NR_BITS-1:0]   out_rd_o,
  output logic [NR_BITS-1:0]   out_rs1_o,
  output logic [NR_BITS-1:0]   out_rs2_o,
  output logic [NR_BITS-1:0]   out_rs3_o,
  output logic                 out_wb_o,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  input  logic                 wb_valid_i,
  input  logic [NW_BITS-1:0]   wb_wid_i,
  input  logic [NR_BITS-1:0]   wb_rd_i,
  input  logic                 wb_eop_i,
  output logic                 stall_timeout_o,
  output logic                 release_err_o
);
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  typedef struct packed {
    logic [NW_BITS-1:0]   wid;
    logic [NR_BITS-1:0]   rd;
    logic [NR_BITS-1:0]   rs1;
    logic [NR_BITS-1:0]   rs2;
    logic [NR_BITS-1:0]   rs3;
    logic                 wb;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_q, busy_d, busy_eff, rel_mask, set_mask;
  slot_t            slot_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d, rel_err_q, rel_err_d;
  logic             rel, hazard, fire, stall;
  logic [NUM_REGS-1:0] row, one_hot;

  assign rel     = wb_valid_i && wb_eop_i;
  assign one_hot = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Set mask is applied after the release mask so a same-cycle re-reserve wins.
  // Bit 0 is never set, so x0 never reads as busy.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign rel_mask[w] = (rel && wb_wid_i == NW_BITS'(w)) ? (one_hot << wb_rd_i) : '0;
    assign set_mask[w] = (fire && in_wb_i && in_wid_i == NW_BITS'(w) && in_rd_i != '0)
                         ? (one_hot << in_rd_i) : '0;
    assign busy_eff[w] = busy_q[w] & ~rel_mask[w];
    assign busy_d[w]   = busy_eff[w] | set_mask[w];
  end

  assign row    = busy_eff[in_wid_i];
  assign hazard = row[in_rs1_i] || row[in_rs2_i] || (in_use_rs3_i && row[in_rs3_i]) ||
                  (in_wb_i && row[in_rd_i]);
  assign in_ready_o = !hazard && (!out_valid_q || out_ready_i);
  assign fire       = in_valid_i && in_ready_o;
  assign stall      = in_valid_i && hazard;

  always_comb begin
    cnt_d = '0;
    if (stall) cnt_d = (cnt_q == CNT_W'(STALL_LIMIT)) ? cnt_q : cnt_q + 1'b1;
    timeout_d = timeout_q || (cnt_d == CNT_W'(STALL_LIMIT));
    rel_err_d = rel_err_q || (rel && !busy_q[wb_wid_i][wb_rd_i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      rel_err_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      rel_err_q <= rel_err_d;
      if (fire) begin
        slot_q      <= '{wid: in_wid_i, rd: in_rd_i, rs1: in_rs1_i, rs2: in_rs2_i,
                         rs3: in_rs3_i, wb: in_wb_i, payload: in_payload_i};
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_wid_o       = slot_q.wid;
  assign out_rd_o        = slot_q.rd;
  assign out_rs1_o       = slot_q.rs1;
  assign out_rs2_o       = slot_q.rs2;
  assign out_rs3_o       = slot_q.rs3;
  assign out_wb_o        = slot_q.wb;
  assign out_payload_o   = slot_q.payload;
  assign stall_timeout_o = timeout_q;
  assign release_err_o   = rel_err_q;
endmodule
